// File: rtl/maze_pkg.sv
// Shared maze definitions: move encodings, grid geometry, executor states and move helpers.
// Pure declarations; no timing or flow control of its own.
package maze_pkg;

  localparam logic [3:0] UP    = 4'b0001;
  localparam logic [3:0] DOWN  = 4'b0010;
  localparam logic [3:0] LEFT  = 4'b0100;
  localparam logic [3:0] RIGHT = 4'b1000;

  localparam int GRID_DIM = 10;

  localparam logic [3:0] START_ROW = 4'd9;
  localparam logic [3:0] START_COL = 4'd0;
  localparam logic [3:0] END_ROW   = 4'd0;
  localparam logic [3:0] END_COL   = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE,
    ERROR
  } exec_state_t;

  // True when dir is a legal one-hot move that keeps (row, col) inside 0..last.
  function automatic logic move_ok(input logic [3:0] dir, input logic [3:0] row,
                                   input logic [3:0] col, input logic [3:0] last);
    case (dir)
      UP:      move_ok = (row != 4'd0);
      DOWN:    move_ok = (row < last);
      LEFT:    move_ok = (col != 4'd0);
      RIGHT:   move_ok = (col < last);
      default: move_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] step_pos(input logic [3:0] dir, input logic [3:0] row,
                                          input logic [3:0] col);
    logic [3:0] r;
    logic [3:0] c;
    r = row;
    c = col;
    case (dir)
      UP:      r = row - 4'd1;
      DOWN:    r = row + 4'd1;
      LEFT:    c = col - 4'd1;
      RIGHT:   c = col + 4'd1;
      default: ;
    endcase
    step_pos = {r, c};
  endfunction

endpackage

// File: rtl/path_executor_if.sv
// Bundle between the backtrace stage / rover controller and the path executor.
// master drives path writes, control and move_ready; slave returns move handshake and status.
interface path_executor_if;
  logic       path_write_en;
  logic [6:0] path_write_index;
  logic [3:0] path_write_data;
  logic [6:0] path_length;
  logic       backtrace_done;
  logic       abort;
  logic       move_ready;
  logic       move_valid;
  logic [3:0] move_dir;
  logic [3:0] rover_row;
  logic [3:0] rover_col;
  logic [6:0] move_count;
  logic       exec_busy;
  logic       exec_done;
  logic       exec_error;

  modport master (
    output path_write_en, path_write_index, path_write_data, path_length,
           backtrace_done, abort, move_ready,
    input  move_valid, move_dir, rover_row, rover_col, move_count,
           exec_busy, exec_done, exec_error
  );

  modport slave (
    input  path_write_en, path_write_index, path_write_data, path_length,
           backtrace_done, abort, move_ready,
    output move_valid, move_dir, rover_row, rover_col, move_count,
           exec_busy, exec_done, exec_error
  );
endinterface

// File: rtl/path_ram.sv
// Path move buffer: DEPTH x 4, synchronous write, combinational read, contents not reset.
// Writes at or beyond DEPTH are dropped; out-of-range reads return 0000.
module path_ram #(
  parameter int DEPTH = 100
) (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [6:0] rd_addr,
  output logic [3:0] rd_data
);
  localparam logic [6:0] DEPTH_L = 7'(DEPTH);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH_L)) mem[wr_addr] <= wr_data;
  end

  assign rd_data = (rd_addr < DEPTH_L) ? mem[rd_addr] : 4'b0000;
endmodule

// File: rtl/path_executor.sv
// Replays a stored path as valid/ready moves and tracks the rover; move valid one cycle after done rises.
// Holds move_dir while move_ready is low; one move per clock while ready is held.
module path_executor #(
  parameter int GRID_DIM   = 10,
  parameter int PATH_DEPTH = 100
) (
  input logic            clk,
  input logic            rst,
  path_executor_if.slave bus
);
  import maze_pkg::*;

  localparam logic [3:0] LAST    = 4'(GRID_DIM - 1);
  localparam logic [6:0] DEPTH_L = 7'(PATH_DEPTH);

  exec_state_t state, state_nxt;
  logic [6:0]  len, len_nxt, idx, idx_nxt, cnt, cnt_nxt;
  logic [3:0]  row, row_nxt, col, col_nxt, dir, dir_nxt;
  logic        vld, vld_nxt, busy, busy_nxt, done, done_nxt, err, err_nxt;
  logic        done_q;
  logic [6:0]  rd_addr;
  logic [3:0]  rd_data;
  logic [7:0]  pos_nxt;

  path_ram #(.DEPTH(PATH_DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (bus.path_write_en),
    .wr_addr (bus.path_write_index),
    .wr_data (bus.path_write_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Lookahead read: the move after the one currently presented.
  assign rd_addr = (state == IDLE) ? 7'd0 : idx + 7'd1;
  assign pos_nxt = step_pos(dir, row, col);

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    row_nxt   = row;
    col_nxt   = col;
    dir_nxt   = dir;
    vld_nxt   = vld;
    busy_nxt  = busy;
    done_nxt  = done;
    err_nxt   = err;
    if (bus.abort) begin
      state_nxt = IDLE;
      vld_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.backtrace_done && !done_q) begin
            len_nxt = bus.path_length;
            idx_nxt = 7'd0;
            cnt_nxt = 7'd0;
            row_nxt = START_ROW;
            col_nxt = START_COL;
            if (bus.path_length == 7'd0) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else if ((bus.path_length > DEPTH_L) ||
                         !move_ok(rd_data, START_ROW, START_COL, LAST)) begin
              state_nxt = ERROR;
              err_nxt   = 1'b1;
            end else begin
              state_nxt = ISSUE;
              vld_nxt   = 1'b1;
              busy_nxt  = 1'b1;
              dir_nxt   = rd_data;
            end
          end
        end
        ISSUE: begin
          if (vld && bus.move_ready) begin
            row_nxt = pos_nxt[7:4];
            col_nxt = pos_nxt[3:0];
            cnt_nxt = cnt + 7'd1;
            idx_nxt = idx + 7'd1;
            if (idx + 7'd1 == len) begin
              state_nxt = DONE;
              vld_nxt   = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else if (!move_ok(rd_data, pos_nxt[7:4], pos_nxt[3:0], LAST)) begin
              state_nxt = ERROR;
              vld_nxt   = 1'b0;
              busy_nxt  = 1'b0;
              err_nxt   = 1'b1;
            end else begin
              dir_nxt = rd_data;
            end
          end
        end
        DONE, ERROR: begin
          if (!bus.backtrace_done) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      len    <= 7'd0;
      idx    <= 7'd0;
      cnt    <= 7'd0;
      row    <= START_ROW;
      col    <= START_COL;
      dir    <= 4'b0000;
      vld    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      len    <= len_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      row    <= row_nxt;
      col    <= col_nxt;
      dir    <= dir_nxt;
      vld    <= vld_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      done_q <= bus.backtrace_done;
    end
  end

  assign bus.move_valid = vld;
  assign bus.move_dir   = dir;
  assign bus.rover_row  = row;
  assign bus.rover_col  = col;
  assign bus.move_count = cnt;
  assign bus.exec_busy  = busy;
  assign bus.exec_done  = done;
  assign bus.exec_error = err;
endmodule

// File: doc/path_executor.md
PATH_EXECUTOR -- requirements
Module: path_executor

Interface
REQ-001 SHALL have parameter GRID_DIM, default 10, which is the maze side length in cells.
REQ-002 SHALL have parameter PATH_DEPTH, default 100, which is the path buffer depth in moves.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have port path_write_en, input, 1 bit: the path buffer write strobe from the backtrace stage.
REQ-006 SHALL have port path_write_index, input, 7 bits: the path buffer write address.
REQ-007 SHALL have port path_write_data, input, 4 bits: the one-hot forward move (UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000).
REQ-008 SHALL have port path_length, input, 7 bits: the number of valid moves, stable while backtrace_done is high.
REQ-009 SHALL have port backtrace_done, input, 1 bit: path complete; a level held until the upstream stage is released.
REQ-010 SHALL have port abort, input, 1 bit: a synchronous cancel of execution.
REQ-011 SHALL have port move_ready, input, 1 bit: the rover motion controller accepts a move.
REQ-012 SHALL have port move_valid, output, 1 bit: move_dir holds a move to execute.
REQ-013 SHALL have port move_dir, output, 4 bits: the one-hot move.
REQ-014 SHALL have port rover_row and rover_col, outputs, 4 bits each: the rover's current cell.
REQ-015 SHALL have port move_count, output, 7 bits: the number of moves accepted.
REQ-016 SHALL have port exec_busy, exec_done and exec_error, outputs, 1 bit each: status flags.

Function
REQ-017 SHALL write path_write_data into buffer[path_write_index] on each clock with path_write_en=1 and index<PATH_DEPTH, in any state; other writes SHALL be ignored.
REQ-018 SHALL be a state machine with states IDLE, ISSUE, DONE and ERROR; all outputs SHALL be registered.
REQ-019 In IDLE, on the first edge sampling backtrace_done=1 with the previous sample 0, SHALL latch len=path_length, set idx=0, rover=(START_ROW=9, START_COL=0) and move_count=0.
REQ-020 Same edge: len=0 -> DONE; len>PATH_DEPTH -> ERROR; otherwise the buffer[0] check of REQ-022 SHALL apply, and if it passes -> ISSUE with move_valid=1 and move_dir=buffer[0], giving one-cycle latency.
REQ-021 In ISSUE, move_dir SHALL stay stable while move_valid=1 and move_ready=0.
REQ-022 On move_valid&&move_ready: update rover (UP row-1, DOWN row+1, LEFT col-1, RIGHT col+1), move_count+1, idx+1; if idx+1==len -> DONE, move_valid=0; otherwise present buffer[idx+1] on the next cycle, so back-to-back moves run at 1 per clock while ready is held.
REQ-023 Before a move is presented, the next move SHALL be checked: not one-hot, or would leave 0..GRID_DIM-1 from the post-update position -> ERROR, move_valid=0, exec_error=1, and the move SHALL NOT be presented.
REQ-024 In DONE, SHALL hold exec_done=1; in DONE or ERROR, backtrace_done=0 -> IDLE and exec_done=exec_error=0 on the next edge.
REQ-025 abort=1 in any state SHALL force IDLE next edge with move_valid=0 and flags cleared, keeping rover/move_count; abort SHALL take priority over a simultaneous handshake.
REQ-026 A backtrace_done fall during ISSUE SHALL be ignored, and execution SHALL complete.
REQ-027 exec_busy SHALL equal 1 exactly in ISSUE.
REQ-028 A backtrace_done still high after return to IDLE SHALL NOT restart execution; a fresh 0->1 edge is required.

Reset
REQ-029 rst SHALL force IDLE, move_valid=0, move_dir=0000, rover=(9,0), move_count=0, exec_busy=exec_done=exec_error=0, idx=len=0, and the done-edge history bit=0.
REQ-030 The path buffer SHALL NOT be reset.
REQ-031 Reset asserted mid-ISSUE SHALL drop move_valid immediately, asynchronously.

Structure
REQ-032 Shared package maze_pkg SHALL hold the direction encodings UP/DOWN/LEFT/RIGHT, GRID_DIM, START_ROW/START_COL, END_ROW=0/END_COL=9 and the exec state enum.
REQ-033 The buffer SHALL be the sub-module path_ram (PATH_DEPTH x 4, synchronous write, combinational read).

Verification
REQ-034 Scenario: write RIGHT,RIGHT,UP at idx 0..2, len=3, done rise, ready=1 -> valid 1 cycle later, 3 consecutive handshakes, rover (8,2), exec_done=1, move_count=3.
REQ-035 Scenario: same path, ready toggling 0,0,1 per move -> move_dir stable during stalls, exactly 3 accepts.
REQ-036 Scenario: buffer[0]=LEFT from (9,0) -> no valid, exec_error=1; done dropped -> IDLE, flags 0.
REQ-037 Scenario: buffer[1]=0011 -> one move accepted, then ERROR, move_count=1.
REQ-038 Scenario: len=0 -> exec_done next cycle, move_valid never 1; done kept high after return to IDLE -> no restart.
REQ-039 Scenario: abort with valid&&ready at move 2, and rst mid-ISSUE -> no accept, IDLE; reset values per REQ-029.
